// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit and the controller: widths, opcodes,
// fetch FSM encoding and the jump-condition decode.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int PC_W    = 8;

  localparam logic [3:0] OP_NOP      = 4'b0000;
  localparam logic [3:0] OP_JMPZ_REG = 4'b0110;
  localparam logic [3:0] OP_JMPZ_IMM = 4'b0111;
  localparam logic [3:0] OP_JMPC_REG = 4'b1000;
  localparam logic [3:0] OP_JMPC_IMM = 4'b1010;
  localparam logic [3:0] OP_HALT     = 4'b1111;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    S_PRIME = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  // Flag selected by a conditional-jump opcode; non-jump opcodes never branch.
  function automatic logic branch_cond(input logic [3:0] op, input logic z, input logic c);
    logic cond;
    case (op)
      OP_JMPZ_REG, OP_JMPZ_IMM: cond = z;
      OP_JMPC_REG, OP_JMPC_IMM: cond = c;
      default:                  cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Next-PC selection: taken jumps, sequential increment or hold, modulo 256.
import cpu_pkg::*;

module branch_resolve (
  input  logic [PC_W-1:0] pc,
  input  logic [3:0]      opcode,
  input  logic [3:0]      imm,
  input  logic            z,
  input  logic            c,
  input  logic            load_pc,
  input  logic            inc_pc,
  input  logic            sel_pc,
  input  logic [PC_W-1:0] reg_data,
  output logic [PC_W-1:0] pc_next,
  output logic            taken
);

  logic cond_s;

  // LoadPC outranks IncPC; SelPC is only looked at once a jump is taken.
  always_comb begin
    cond_s  = branch_cond(opcode, z, c);
    taken   = 1'b0;
    pc_next = pc;
    if (load_pc && cond_s) begin
      taken   = 1'b1;
      pc_next = sel_pc ? {4'h0, imm} : reg_data;
    end else if (load_pc) begin
      pc_next = pc + 8'd1;
    end else if (inc_pc) begin
      pc_next = pc + 8'd1;
    end else begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR and the prime/run/halt sequencer, with a NOP
// bubble injected into IR whenever a jump is taken.
import cpu_pkg::*;

module fetch_unit (
  input  logic       Clk,
  input  logic       CLB,
  input  logic       LoadIR,
  input  logic       IncPC,
  input  logic       SelPC,
  input  logic       LoadPC,
  input  logic       Z,
  input  logic       C,
  input  logic [7:0] RegData,
  input  logic [7:0] IMemData,
  output logic [7:0] IMemAddr,
  output logic [3:0] Opcode,
  output logic [3:0] Imm,
  output logic       Halted,
  output logic       JumpTaken
);

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 jump_q, jump_d;
  logic                 halted_q, halted_d;
  logic [PC_W-1:0]      br_pc_s;
  logic                 br_taken_s;

  branch_resolve u_branch_resolve (
    .pc       (pc_q),
    .opcode   (ir_q[7:4]),
    .imm      (ir_q[3:0]),
    .z        (Z),
    .c        (C),
    .load_pc  (LoadPC),
    .inc_pc   (IncPC),
    .sel_pc   (SelPC),
    .reg_data (RegData),
    .pc_next  (br_pc_s),
    .taken    (br_taken_s)
  );

  // Next-state decode; S_PRIME and S_HALT never consult the controller.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    jump_d  = 1'b0;
    case (state_q)
      S_PRIME: begin
        ir_d    = IMemData;
        pc_d    = pc_q + 8'd1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (ir_q[7:4] == OP_HALT) begin
          state_d = S_HALT;
        end else if (br_taken_s) begin
          pc_d   = br_pc_s;
          ir_d   = NOP_INSTR;
          jump_d = 1'b1;
        end else begin
          pc_d = br_pc_s;
          if (LoadIR) begin
            ir_d = IMemData;
          end else begin
            ir_d = ir_q;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_PRIME;
        pc_d    = 8'h00;
        ir_d    = NOP_INSTR;
      end
    endcase
    halted_d = (state_d == S_HALT);
  end

  // State registers, cleared asynchronously by CLB.
  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB) begin
      state_q  <= S_PRIME;
      pc_q     <= 8'h00;
      ir_q     <= NOP_INSTR;
      jump_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      jump_q   <= jump_d;
      halted_q <= halted_d;
    end
  end

  assign IMemAddr  = pc_q;
  assign Opcode    = ir_q[7:4];
  assign Imm       = ir_q[3:0];
  assign Halted    = halted_q;
  assign JumpTaken = jump_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expectations are queued as stimulus is
// applied and popped against the DUT one step later.
module tb_fetch_unit;

  logic       Clk;
  logic       CLB;
  logic       LoadIR, IncPC, SelPC, LoadPC, Z, C;
  logic [7:0] RegData;
  logic [7:0] IMemData;
  logic [7:0] IMemAddr;
  logic [3:0] Opcode, Imm;
  logic       Halted, JumpTaken;

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ir;
    logic       jt;
    logic       hl;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_unit dut (
    .Clk       (Clk),
    .CLB       (CLB),
    .LoadIR    (LoadIR),
    .IncPC     (IncPC),
    .SelPC     (SelPC),
    .LoadPC    (LoadPC),
    .Z         (Z),
    .C         (C),
    .RegData   (RegData),
    .IMemData  (IMemData),
    .IMemAddr  (IMemAddr),
    .Opcode    (Opcode),
    .Imm       (Imm),
    .Halted    (Halted),
    .JumpTaken (JumpTaken)
  );

  assign IMemData = mem[IMemAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic push_exp(input logic [7:0] pc, input logic [7:0] ir, input logic jt, input logic hl);
    exp_t e;
    e.pc = pc; e.ir = ir; e.jt = jt; e.hl = hl;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_ctrl();
    LoadIR = 1'b0; IncPC = 1'b0; SelPC = 1'b0; LoadPC = 1'b0;
    Z = 1'b0; C = 1'b0; RegData = 8'h00;
  endtask

  task automatic reset_dut(input logic [7:0] first);
    mem[0] = first;
    @(negedge Clk);
    CLB = 1'b0;
    idle_ctrl();
    @(negedge Clk);
    CLB = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    mem[0] = 8'h13;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin
          @(negedge Clk);
          LoadIR = 1'b1; IncPC = 1'b1; LoadPC = 1'b1; SelPC = 1'b1; Z = 1'b1; C = 1'b1;
          CLB = 1'b0;
          push_exp(8'h00, 8'h00, 1'b0, 1'b0);
          #1;
        end
        1: begin
          push_exp(8'h00, 8'h00, 1'b0, 1'b0);
          tick();
        end
        2: begin
          @(negedge Clk);
          idle_ctrl();
          CLB = 1'b1;
          push_exp(8'h01, 8'h13, 1'b0, 1'b0);
          tick();
        end
        default: begin
          LoadPC = 1'b1; Z = 1'b1; C = 1'b1; SelPC = 1'b1;
          push_exp(8'h02, 8'h13, 1'b0, 1'b0);
          tick();
        end
      endcase
      e = sb_q.pop_front();
      checks++;
      if ({IMemAddr, Opcode, Imm, JumpTaken, Halted} !== {e.pc, e.ir, e.jt, e.hl}) begin
        failures++;
        $display("FAIL reset step %0d: got pc=%h ir=%h%h jt=%b halted=%b, want pc=%h ir=%h jt=%b halted=%b",
                 s, IMemAddr, Opcode, Imm, JumpTaken, Halted, e.pc, e.ir, e.jt, e.hl);
      end
    end
  endtask

  task automatic test_taken_jump();
    exp_t e;
    mem[5] = 8'hA9;
    reset_dut(8'h75);
    for (int s = 0; s < 6; s++) begin
      idle_ctrl();
      case (s)
        0: push_exp(8'h01, 8'h75, 1'b0, 1'b0);
        1: begin
          Z = 1'b1; LoadPC = 1'b1; SelPC = 1'b1; LoadIR = 1'b1;
          push_exp(8'h05, 8'h00, 1'b1, 1'b0);
        end
        2: push_exp(8'h05, 8'h00, 1'b0, 1'b0);
        3: begin
          LoadIR = 1'b1;
          push_exp(8'h05, 8'hA9, 1'b0, 1'b0);
        end
        4: begin
          C = 1'b1; LoadPC = 1'b1; SelPC = 1'b1;
          push_exp(8'h09, 8'h00, 1'b1, 1'b0);
        end
        default: begin
          LoadPC = 1'b1; Z = 1'b1; C = 1'b1; SelPC = 1'b1;
          push_exp(8'h0A, 8'h00, 1'b0, 1'b0);
        end
      endcase
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({IMemAddr, Opcode, Imm, JumpTaken, Halted} !== {e.pc, e.ir, e.jt, e.hl}) begin
        failures++;
        $display("FAIL taken_jump step %0d: got pc=%h ir=%h%h jt=%b halted=%b, want pc=%h ir=%h jt=%b halted=%b",
                 s, IMemAddr, Opcode, Imm, JumpTaken, Halted, e.pc, e.ir, e.jt, e.hl);
      end
    end
  endtask

  task automatic test_not_taken();
    exp_t e;
    mem[8'h10] = 8'h80;
    mem[8'h11] = 8'h70;
    reset_dut(8'h60);
    for (int s = 0; s < 6; s++) begin
      idle_ctrl();
      case (s)
        0: push_exp(8'h01, 8'h60, 1'b0, 1'b0);
        1: begin
          Z = 1'b1; LoadPC = 1'b1; SelPC = 1'b0; RegData = 8'h10;
          push_exp(8'h10, 8'h00, 1'b1, 1'b0);
        end
        2: begin
          LoadIR = 1'b1;
          push_exp(8'h10, 8'h80, 1'b0, 1'b0);
        end
        3: begin
          C = 1'b0; Z = 1'b1; LoadPC = 1'b1; SelPC = 1'b0; RegData = 8'h40; LoadIR = 1'b1;
          push_exp(8'h11, 8'h80, 1'b0, 1'b0);
        end
        4: begin
          LoadIR = 1'b1; IncPC = 1'b1;
          push_exp(8'h12, 8'h70, 1'b0, 1'b0);
        end
        default: begin
          Z = 1'b0; C = 1'b1; LoadPC = 1'b1; SelPC = 1'b1;
          push_exp(8'h13, 8'h70, 1'b0, 1'b0);
        end
      endcase
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({IMemAddr, Opcode, Imm, JumpTaken, Halted} !== {e.pc, e.ir, e.jt, e.hl}) begin
        failures++;
        $display("FAIL not_taken step %0d: got pc=%h ir=%h%h jt=%b halted=%b, want pc=%h ir=%h jt=%b halted=%b",
                 s, IMemAddr, Opcode, Imm, JumpTaken, Halted, e.pc, e.ir, e.jt, e.hl);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    mem[8'hFF] = 8'h3C;
    reset_dut(8'h60);
    for (int s = 0; s < 3; s++) begin
      idle_ctrl();
      case (s)
        0: push_exp(8'h01, 8'h60, 1'b0, 1'b0);
        1: begin
          Z = 1'b1; LoadPC = 1'b1; RegData = 8'hFF;
          push_exp(8'hFF, 8'h00, 1'b1, 1'b0);
        end
        default: begin
          IncPC = 1'b1; LoadIR = 1'b1;
          push_exp(8'h00, 8'h3C, 1'b0, 1'b0);
        end
      endcase
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({IMemAddr, Opcode, Imm, JumpTaken, Halted} !== {e.pc, e.ir, e.jt, e.hl}) begin
        failures++;
        $display("FAIL wrap step %0d: got pc=%h ir=%h%h jt=%b halted=%b, want pc=%h ir=%h jt=%b halted=%b",
                 s, IMemAddr, Opcode, Imm, JumpTaken, Halted, e.pc, e.ir, e.jt, e.hl);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    mem[8'h22] = 8'h6E;
    reset_dut(8'h80);
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin
          idle_ctrl();
          push_exp(8'h01, 8'h80, 1'b0, 1'b0);
          tick();
        end
        1: begin
          idle_ctrl();
          LoadPC = 1'b1; IncPC = 1'b1; C = 1'b1; SelPC = 1'b0; RegData = 8'h22; LoadIR = 1'b1;
          push_exp(8'h22, 8'h00, 1'b1, 1'b0);
          tick();
        end
        2: begin
          idle_ctrl();
          LoadIR = 1'b1;
          push_exp(8'h22, 8'h6E, 1'b0, 1'b0);
          tick();
        end
        3: begin
          idle_ctrl();
          Z = 1'b1; LoadPC = 1'b1; SelPC = 1'b1;
          push_exp(8'h0E, 8'h00, 1'b1, 1'b0);
          tick();
        end
        default: begin
          #2;
          CLB = 1'b0;
          push_exp(8'h00, 8'h00, 1'b0, 1'b0);
          #1;
        end
      endcase
      e = sb_q.pop_front();
      checks++;
      if ({IMemAddr, Opcode, Imm, JumpTaken, Halted} !== {e.pc, e.ir, e.jt, e.hl}) begin
        failures++;
        $display("FAIL priority step %0d: got pc=%h ir=%h%h jt=%b halted=%b, want pc=%h ir=%h jt=%b halted=%b",
                 s, IMemAddr, Opcode, Imm, JumpTaken, Halted, e.pc, e.ir, e.jt, e.hl);
      end
    end
    @(negedge Clk);
    CLB = 1'b1;
  endtask

  task automatic test_halt();
    exp_t e;
    reset_dut(8'hF0);
    for (int s = 0; s < 14; s++) begin
      case (s)
        0: begin
          idle_ctrl();
          push_exp(8'h01, 8'hF0, 1'b0, 1'b0);
          tick();
        end
        1: begin
          LoadPC = 1'b1; Z = 1'b1; C = 1'b1; IncPC = 1'b1; LoadIR = 1'b1; RegData = 8'h77;
          push_exp(8'h01, 8'hF0, 1'b0, 1'b1);
          tick();
        end
        12: begin
          #2;
          CLB = 1'b0;
          push_exp(8'h00, 8'h00, 1'b0, 1'b0);
          #1;
        end
        13: begin
          @(negedge Clk);
          idle_ctrl();
          CLB = 1'b1;
          push_exp(8'h01, 8'hF0, 1'b0, 1'b0);
          tick();
        end
        default: begin
          LoadIR = 1'($urandom); IncPC = 1'($urandom); LoadPC = 1'($urandom);
          SelPC = 1'($urandom); Z = 1'($urandom); C = 1'($urandom);
          RegData = 8'($urandom);
          mem[1] = 8'($urandom);
          push_exp(8'h01, 8'hF0, 1'b0, 1'b1);
          tick();
        end
      endcase
      e = sb_q.pop_front();
      checks++;
      if ({IMemAddr, Opcode, Imm, JumpTaken, Halted} !== {e.pc, e.ir, e.jt, e.hl}) begin
        failures++;
        $display("FAIL halt step %0d: got pc=%h ir=%h%h jt=%b halted=%b, want pc=%h ir=%h jt=%b halted=%b",
                 s, IMemAddr, Opcode, Imm, JumpTaken, Halted, e.pc, e.ir, e.jt, e.hl);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    for (int i = 0; i < 32; i++) begin
      mem[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
    end
    reset_dut(mem[0]);
    m_pc = 8'h01;
    m_ir = mem[0];
    push_exp(m_pc, m_ir, 1'b0, 1'b0);
    tick();
    for (int s = 0; s < 17; s++) begin
      if (s > 0) begin
        LoadIR = 1'($urandom); IncPC = 1'($urandom); LoadPC = 1'b0;
        SelPC = 1'bx; Z = 1'($urandom); C = 1'($urandom); RegData = 8'($urandom);
        if (LoadIR) m_ir = mem[m_pc];
        if (IncPC) m_pc = m_pc + 8'd1;
        push_exp(m_pc, m_ir, 1'b0, 1'b0);
        tick();
      end
      e = sb_q.pop_front();
      checks++;
      if ({IMemAddr, Opcode, Imm, JumpTaken, Halted} !== {e.pc, e.ir, e.jt, e.hl}) begin
        failures++;
        $display("FAIL back_to_back step %0d: got pc=%h ir=%h%h jt=%b halted=%b, want pc=%h ir=%h jt=%b halted=%b",
                 s, IMemAddr, Opcode, Imm, JumpTaken, Halted, e.pc, e.ir, e.jt, e.hl);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    CLB = 1'b0;
    idle_ctrl();
    test_reset();
    test_taken_jump();
    test_not_taken();
    test_wrap();
    test_priority();
    test_halt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 CLB  input  1  reset, asynchronous, active-low; clears all state immediately when low.
REQ-003 LoadIR  input  1  from controller; load IR from IMemData.
REQ-004 IncPC  input  1  from controller; PC <= PC+1.
REQ-005 SelPC  input  1  from controller; jump source, 1 = immediate, 0 = RegData; ignored when LoadPC=0.
REQ-006 LoadPC  input  1  from controller; conditional jump request.
REQ-007 Z  input  1  accumulator zero flag, sampled at rising edge.
REQ-008 C  input  1  accumulator carry flag, sampled at rising edge.
REQ-009 RegData  input  8  register-file read value, used as the register jump target.
REQ-010 IMemData  input  8  instruction at IMemAddr; combinational memory read.
REQ-011 IMemAddr  output  8  current PC.
REQ-012 Opcode  output  4  IR[7:4]; drives the controller.
REQ-013 Imm  output  4  IR[3:0]; immediate or register index.
REQ-014 Halted  output  1  high while in S_HALT.
REQ-015 JumpTaken  output  1  one-cycle pulse, registered, after a taken jump.

Function
REQ-016 The FSM SHALL have three states: S_PRIME, S_RUN and S_HALT.
REQ-017 In S_PRIME the block SHALL ignore all control inputs, set IR <= IMemData and PC <= PC+1, then go to S_RUN; this is a one-cycle prime after reset.
REQ-018 In S_RUN with Opcode=4'b1111 (HALT), the block SHALL go to S_HALT and hold PC and IR regardless of the other inputs.
REQ-019 Jump condition: cond = Z for opcodes 0110/0111; cond = C for opcodes 1000/1010; cond = 0 for all other opcodes.
REQ-020 S_RUN, LoadPC=1 and cond=1: PC <= (SelPC ? {4'h0,Imm} : RegData); IR <= 8'h00 (NOP bubble, which flushes the fall-through fetch); JumpTaken <= 1.
REQ-021 S_RUN, LoadPC=1 and cond=0: PC <= PC+1; IR <= IMemData if LoadIR=1.
REQ-022 S_RUN, LoadPC=0 and IncPC=1: PC <= PC+1.
REQ-023 S_RUN, LoadPC=0 and IncPC=0: PC holds.
REQ-024 LoadPC SHALL take priority over IncPC when both are 1.
REQ-025 If no taken jump occurs, IR <= IMemData when LoadIR=1; otherwise IR holds.
REQ-026 PC arithmetic SHALL be modulo 256, so 8'hFF+1 wraps to 8'h00 with no flag.
REQ-027 JumpTaken SHALL be 0 in every cycle not covered by REQ-020.
REQ-028 S_HALT SHALL be exited only by reset; PC, IR and all inputs are ignored while in it.
REQ-029 Controller outputs of value X while LoadPC=0 (SelPC) or in S_PRIME/S_HALT SHALL NOT affect any state.

Reset
REQ-030 While CLB=0, outputs SHALL be: PC=8'h00, IR=8'h00 (Opcode=NOP, Imm=0), Halted=0, JumpTaken=0, state=S_PRIME.
REQ-031 CLB asserted at any point, including mid-jump or while in S_HALT, SHALL force the REQ-030 values asynchronously; the first rising edge after deassertion executes S_PRIME.

Structure
REQ-032 Opcode constants (NOP, HALT, JMPZ_REG, JMPZ_IMM, JMPC_REG, JMPC_IMM), INSTR_W=8, PC_W=8, NOP_INSTR=8'h00 and the state encoding SHALL live in a shared package cpu_pkg, also used by the controller.
REQ-033 The next-PC/condition logic (REQ-019 to REQ-024, REQ-026) SHALL be a combinational sub-module, branch_resolve.
REQ-034 PC, IR, state and JumpTaken SHALL be in fetch_unit.

Verification
REQ-035 Reset then prime: CLB low, then high; mem[0]=8'h13 -> after 1 edge: IR=8'h13, PC=1, Opcode=0001.
REQ-036 Taken immediate jump: IR=8'h75, Z=1, LoadPC=1, SelPC=1 -> PC=8'h05, IR=8'h00, JumpTaken=1 for exactly 1 cycle.
REQ-037 Not-taken register jump: IR=8'h80, C=0, LoadPC=1, SelPC=0, RegData=8'h40, PC=8'h10 -> PC=8'h11, IR=mem[8'h10], JumpTaken=0.
REQ-038 Wrap: PC=8'hFF, IncPC=1, LoadIR=1 -> PC=8'h00, IR=mem[8'hFF].
REQ-039 Halt: IR=8'hF0 -> Halted=1, PC frozen for 10 cycles under random controls; CLB pulse mid-cycle -> PC=0, Halted=0 immediately.
REQ-040 Priority: LoadPC=1, IncPC=1, taken JMPC_REG, C=1, RegData=8'h22 -> PC=8'h22.
